// File: rtl/act_mem_write_packer.sv
// Packs a serial or N-wide activation stream into N-lane words and writes them to
// consecutive word addresses of the activation memory, starting at a latched base.
module act_mem_write_packer #(
    parameter int N_DIM_ARRAY     = 8,
    parameter int N_DIM_ARRAY_LOG = 3,
    parameter int ACT_DATA_WIDTH  = 8,
    parameter int ADDR_W          = 12,
    parameter int CNT_W           = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  parallel_mode,
    input  logic [CNT_W-1:0]                      num_elements,
    input  logic [ADDR_W-1:0]                     base_addr,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] in_data,
    output logic                                  wr_en,
    output logic [ADDR_W-1:0]                     wr_addr_input,
    output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] wr_input_word,
    output logic                                  busy,
    output logic                                  done
);

    localparam int WORD_W = N_DIM_ARRAY * ACT_DATA_WIDTH;
    localparam logic [N_DIM_ARRAY_LOG-1:0] LAST_LANE = N_DIM_ARRAY_LOG'(N_DIM_ARRAY - 1);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

    state_t                     state, state_nxt;
    logic [N_DIM_ARRAY_LOG-1:0] lane_idx;
    logic [CNT_W-1:0]           elem_cnt;
    logic [CNT_W-1:0]           num_lat;
    logic [ADDR_W-1:0]          word_idx;
    logic [ADDR_W-1:0]          base_lat;
    logic                       par_lat;
    logic [WORD_W-1:0]          pack_reg;

    logic                       beat;
    logic [CNT_W-1:0]           remaining;
    logic                       last_beat;
    logic [WORD_W-1:0]          serial_word;
    logic [WORD_W-1:0]          par_word;

    assign in_ready  = (state == PACK);
    assign busy      = (state != IDLE);
    assign beat      = in_valid & in_ready;
    assign remaining = num_lat - elem_cnt;
    assign last_beat = par_lat ? (remaining <= CNT_W'(N_DIM_ARRAY)) : (remaining == CNT_W'(1));

    // Serial word: current partial word with the incoming element dropped into its lane.
    always_comb begin
        serial_word = pack_reg;
        serial_word[lane_idx*ACT_DATA_WIDTH +: ACT_DATA_WIDTH] = in_data[ACT_DATA_WIDTH-1:0];
    end

    // Parallel word: lanes beyond the elements still owed by the job are zeroed.
    always_comb begin
        par_word = '0;
        for (int k = 0; k < N_DIM_ARRAY; k++) begin
            if (CNT_W'(k) < remaining)
                par_word[k*ACT_DATA_WIDTH +: ACT_DATA_WIDTH] = in_data[k*ACT_DATA_WIDTH +: ACT_DATA_WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (num_elements == '0) ? DONE : PACK;
            PACK:  if (beat && last_beat)
                       state_nxt = (par_lat || lane_idx == LAST_LANE) ? DONE : FLUSH;
            FLUSH: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lane_idx      <= '0;
            elem_cnt      <= '0;
            num_lat       <= '0;
            word_idx      <= '0;
            base_lat      <= '0;
            par_lat       <= 1'b0;
            pack_reg      <= '0;
            wr_en         <= 1'b0;
            wr_addr_input <= '0;
            wr_input_word <= '0;
            done          <= 1'b0;
        end else begin
            state <= state_nxt;
            wr_en <= 1'b0;
            // done trails the DONE state by one cycle so it follows the final write.
            done  <= (state == DONE);
            case (state)
                IDLE: if (start) begin
                    par_lat  <= parallel_mode;
                    num_lat  <= num_elements;
                    base_lat <= base_addr;
                    lane_idx <= '0;
                    elem_cnt <= '0;
                    word_idx <= '0;
                    pack_reg <= '0;
                end
                PACK: if (beat) begin
                    if (par_lat) begin
                        wr_en         <= 1'b1;
                        wr_input_word <= par_word;
                        wr_addr_input <= base_lat + word_idx;
                        word_idx      <= word_idx + ADDR_W'(1);
                        elem_cnt      <= last_beat ? num_lat : elem_cnt + CNT_W'(N_DIM_ARRAY);
                    end else begin
                        elem_cnt <= elem_cnt + CNT_W'(1);
                        lane_idx <= lane_idx + N_DIM_ARRAY_LOG'(1);
                        if (lane_idx == LAST_LANE) begin
                            wr_en         <= 1'b1;
                            wr_input_word <= serial_word;
                            wr_addr_input <= base_lat + word_idx;
                            word_idx      <= word_idx + ADDR_W'(1);
                            pack_reg      <= '0;
                        end else begin
                            pack_reg <= serial_word;
                        end
                    end
                end
                FLUSH: begin
                    wr_en         <= 1'b1;
                    wr_input_word <= pack_reg;
                    wr_addr_input <= base_lat + word_idx;
                    word_idx      <= word_idx + ADDR_W'(1);
                    pack_reg      <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_act_mem_write_packer.sv
// Directed bench for act_mem_write_packer: expected writes go to a scoreboard queue
// as stimulus is driven and are popped whenever the packer strobes wr_en.
module tb_act_mem_write_packer;

    localparam int N  = 8;
    localparam int AW = 8;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;
    localparam int WW = N * AW;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              parallel_mode = 1'b0;
    logic [CNT_W-1:0]  num_elements = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WW-1:0]     in_data = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr_input;
    logic [WW-1:0]     wr_input_word;
    logic              busy;
    logic              done;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    logic [ADDR_W+WW-1:0] sb[$];

    act_mem_write_packer #(
        .N_DIM_ARRAY(N), .N_DIM_ARRAY_LOG(3), .ACT_DATA_WIDTH(AW),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .parallel_mode(parallel_mode),
        .num_elements(num_elements), .base_addr(base_addr), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .wr_en(wr_en),
        .wr_addr_input(wr_addr_input), .wr_input_word(wr_input_word),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word whose first `count` lanes hold first, first+1, ...; remaining lanes zero.
    function automatic logic [WW-1:0] seq_word(input int first, input int count);
        logic [WW-1:0] w = '0;
        for (int k = 0; k < count; k++) w[k*AW +: AW] = AW'(first + k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [WW-1:0] w);
        sb.push_back({a, w});
    endtask

    task automatic start_job(input logic par, input int num, input logic [ADDR_W-1:0] base);
        parallel_mode = par;
        num_elements  = CNT_W'(num);
        base_addr     = base;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && wr_en) begin
            logic [ADDR_W+WW-1:0] e;
            wr_cnt++;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_wr: observed addr %0h word %0h, expected no write",
                       wr_addr_input, wr_input_word);
            end else begin
                e = sb.pop_front();
                check("wr_addr", WW'(wr_addr_input), WW'(e[ADDR_W+WW-1:WW]));
                check("wr_word", wr_input_word, e[WW-1:0]);
            end
        end
    end

    initial begin
        int wr_before;

        // Reset state
        #12;
        check("rst_in_ready", WW'(in_ready), '0);
        check("rst_wr_en", WW'(wr_en), '0);
        check("rst_busy", WW'(busy), '0);
        check("rst_done", WW'(done), '0);
        check("rst_word", wr_input_word, '0);
        tick();
        reset = 1'b1;
        tick();

        // Serial, 16 elements back-to-back, two full words
        push(12'h010, seq_word(1, 8));
        push(12'h011, seq_word(9, 8));
        start_job(1'b0, 16, 12'h010);
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = WW'(i);
            check("ser16_ready", WW'(in_ready), WW'(1));
            tick();
        end
        in_valid = 1'b0;
        check("ser16_wr_last", WW'(wr_en), WW'(1));
        check("ser16_done_early", WW'(done), '0);
        tick();
        check("ser16_done", WW'(done), WW'(1));
        tick();
        check("ser16_done_pulse", WW'(done), '0);
        check("ser16_idle", WW'(busy), '0);

        // Serial, 5 elements: partial word flushed with zeroed tail
        push(12'h000, seq_word(1, 5));
        start_job(1'b0, 5, 12'h000);
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = WW'(i);
            tick();
        end
        in_valid = 1'b0;
        check("flush_not_yet", WW'(wr_en), '0);
        check("flush_busy", WW'(busy), WW'(1));
        tick();
        check("flush_wr", WW'(wr_en), WW'(1));
        tick();
        check("flush_done", WW'(done), WW'(1));

        // Parallel, 20 elements from 0xFFE: address wrap, last word lanes 4-7 zeroed
        push(12'hFFE, seq_word(1, 8));
        push(12'hFFF, seq_word(9, 8));
        push(12'h000, seq_word(17, 4));
        start_job(1'b1, 20, 12'hFFE);
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = seq_word(1 + 8*b, 8);
            tick();
        end
        in_valid = 1'b0;
        check("par_wr_last", WW'(wr_en), WW'(1));
        tick();
        check("par_done", WW'(done), WW'(1));
        check("par_ready_after", WW'(in_ready), '0);

        // Zero-length job: done two cycles after start, no write
        tick();
        wr_before = wr_cnt;
        start_job(1'b0, 0, 12'h123);
        check("zero_done_early", WW'(done), '0);
        check("zero_busy", WW'(busy), WW'(1));
        tick();
        check("zero_done", WW'(done), WW'(1));
        tick();
        check("zero_done_pulse", WW'(done), '0);
        check("zero_no_wr", WW'(wr_cnt), WW'(wr_before));

        // Serial with gaps, second start mid-job must be ignored
        wr_before = wr_cnt;
        push(12'h100, seq_word(8'h21, 8));
        start_job(1'b0, 8, 12'h100);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = WW'(8'h21 + i);
            tick();
            in_valid = 1'b0;
            in_data  = WW'(8'hEE);
            if (i == 2) begin
                parallel_mode = 1'b1;
                num_elements  = CNT_W'(3);
                base_addr     = 12'h555;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("gap_done", WW'(done), WW'(1));
        check("gap_one_wr", WW'(wr_cnt), WW'(wr_before + 1));
        tick();

        // Reset mid-job after 3 elements, then a clean job
        start_job(1'b0, 8, 12'h200);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = WW'(8'h71 + i);
            tick();
        end
        reset = 1'b0;
        #1;
        check("mrst_wr_en", WW'(wr_en), '0);
        check("mrst_busy", WW'(busy), '0);
        check("mrst_ready", WW'(in_ready), '0);
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        push(12'h300, seq_word(8'h81, 8));
        start_job(1'b0, 8, 12'h300);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = WW'(8'h81 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("post_rst_done", WW'(done), WW'(1));
        tick();
        tick();
        check("sb_empty", WW'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
